// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared UART constants and FIFO sizing helpers
package uart_tx_fifo_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int CLOCK_FREQ      = 50_000_000;
    localparam int BAUD_RATE       = 115_200;
    localparam int TX_FIFO_DEPTH   = 8;
    localparam int OVF_CNT_W       = 16;

    function automatic bit is_pow2_ge2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// rtl/uart_tx_fifo_mem.sv - DEPTH x WIDTH register array, one write port, one async read port
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents survive reset on purpose; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - first-word fall-through FIFO feeding the UART transmitter; UART_TX_FIFO_STATS_EN adds overflow_cnt
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH = TX_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           enq_data,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    output logic [WIDTH-1:0]           deq_data,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH):0]     count
`ifdef UART_TX_FIFO_STATS_EN
   ,output logic [OVF_CNT_W-1:0]       overflow_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (!is_pow2_ge2(DEPTH)) begin : g_depth_check
        $error("uart_tx_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    // Extra MSB on each pointer tells a full ring from an empty one.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

    assign w_push = enq_valid && !w_full;
    assign w_pop  = deq_ready && !w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    assign enq_ready = !w_full;
    assign deq_valid = !w_empty;
    assign count     = r_wr_ptr - r_rd_ptr;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr[AW-1:0]),
        .wdata (enq_data),
        .raddr (r_rd_ptr[AW-1:0]),
        .rdata (deq_data)
    );

`ifdef UART_TX_FIFO_STATS_EN
    logic [OVF_CNT_W-1:0] r_overflow_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow_cnt <= '0;
        end else if (enq_valid && w_full && (r_overflow_cnt != {OVF_CNT_W{1'b1}})) begin
            r_overflow_cnt <= r_overflow_cnt + OVF_CNT_W'(1);
        end
    end

    assign overflow_cnt = r_overflow_cnt;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo against a queue model
module tb_uart_tx_fifo;

    localparam int W = 8;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] enq_data = '0;
    logic         enq_valid = 1'b0;
    logic         enq_ready;
    logic [W-1:0] deq_data;
    logic         deq_valid;
    logic         deq_ready = 1'b0;
    logic [3:0]   count;
`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0]  overflow_cnt;
`endif

    uart_tx_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .enq_data     (enq_data),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .deq_data     (deq_data),
        .deq_valid    (deq_valid),
        .deq_ready    (deq_ready),
        .count        (count)
`ifdef UART_TX_FIFO_STATS_EN
       ,.overflow_cnt (overflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] popped[$];
    int unsigned  m_ovf = 0;
    bit           model_ok = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: an ideal bounded queue, updated with the inputs present at each edge.
    always @(posedge clk) begin
        bit m_full;
        bit m_empty;
        if (reset) begin
            mq.delete();
            m_ovf = 0;
            model_ok = 1'b1;
        end else begin
            m_full  = (mq.size() == D);
            m_empty = (mq.size() == 0);
            if (deq_ready && !m_empty) popped.push_back(mq.pop_front());
            if (enq_valid && !m_full) mq.push_back(enq_data);
            if (enq_valid && m_full && m_ovf != 32'hFFFF) m_ovf++;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("count", count, mq.size());
            chk("enq_ready", enq_ready, mq.size() != D);
            chk("deq_valid", deq_valid, mq.size() != 0);
            if (mq.size() != 0) chk("deq_data", deq_data, mq[0]);
`ifdef UART_TX_FIFO_STATS_EN
            chk("overflow_cnt", overflow_cnt, m_ovf);
`endif
        end
    end

    task automatic cyc(input bit ev, input logic [W-1:0] ed, input bit dr);
        enq_valid = ev;
        enq_data  = ed;
        deq_ready = dr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: idle after reset
        repeat (10) cyc(0, 8'h00, 0);
        chk("t1_count", count, 0);
        chk("t1_enq_ready", enq_ready, 1);
        chk("t1_deq_valid", deq_valid, 0);

        // 2: three bytes, then drain
        cyc(1, 8'h41, 0);
        cyc(1, 8'h42, 0);
        cyc(1, 8'h43, 0);
        chk("t2_count", count, 3);
        chk("t2_head", deq_data, 8'h41);
        popped.delete();
        repeat (3) cyc(0, 8'h00, 1);
        chk("t2_npop", popped.size(), 3);
        chk("t2_pop0", popped[0], 8'h41);
        chk("t2_pop1", popped[1], 8'h42);
        chk("t2_pop2", popped[2], 8'h43);
        chk("t2_empty", deq_valid, 0);

        // 3: fill to DEPTH, refused 9th push, drain
        for (int i = 0; i < D; i++) cyc(1, W'(i), 0);
        chk("t3_enq_ready", enq_ready, 0);
        chk("t3_count", count, 8);
        cyc(1, 8'hFF, 0);
        chk("t3_count_after_refuse", count, 8);
`ifdef UART_TX_FIFO_STATS_EN
        chk("t3_overflow", overflow_cnt, 1);
`endif
        popped.delete();
        repeat (D + 1) cyc(0, 8'h00, 1);
        chk("t3_npop", popped.size(), 8);
        for (int i = 0; i < D; i++) chk("t3_pop", popped[i], i);
        chk("t3_empty", deq_valid, 0);

        // 4: push against full while popping
        for (int i = 0; i < D; i++) cyc(1, W'(8'h10 + i), 0);
        popped.delete();
        cyc(1, 8'h99, 1);
        chk("t4_count_pop_only", count, 7);
        chk("t4_first_pop", popped[0], 8'h10);
        cyc(1, 8'h99, 0);
        chk("t4_count_refill", count, 8);
        repeat (D) cyc(0, 8'h00, 1);
        chk("t4_npop", popped.size(), 9);
        chk("t4_last", popped[8], 8'h99);

        // 5: steady occupancy of 4 across pointer wrap
        popped.delete();
        for (int i = 0; i < 4; i++) cyc(1, W'(8'h20 + i), 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, W'(8'h24 + i), 1);
            chk("t5_count", count, 4);
        end
        repeat (4) cyc(0, 8'h00, 1);
        chk("t5_npop", popped.size(), 24);
        for (int i = 0; i < 24; i++) chk("t5_order", popped[i], 8'h20 + i);

        // 6: reset with five bytes queued
        for (int i = 0; i < 5; i++) cyc(1, W'(8'h30 + i), 0);
        chk("t6_count_pre", count, 5);
        reset = 1'b1;
        cyc(1, 8'h77, 1);
        reset = 1'b0;
        chk("t6_count", count, 0);
        chk("t6_deq_valid", deq_valid, 0);
        chk("t6_enq_ready", enq_ready, 1);
`ifdef UART_TX_FIFO_STATS_EN
        chk("t6_overflow", overflow_cnt, 0);
`endif
        popped.delete();
        cyc(1, 8'h5A, 0);
        chk("t6_head", deq_data, 8'h5A);
        cyc(0, 8'h00, 1);
        chk("t6_npop", popped.size(), 1);
        chk("t6_pop", popped[0], 8'h5A);
        chk("t6_count_end", count, 0);

        cyc(0, 8'h00, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
